// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage controller.
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
  localparam int ARQ_DEF     = 16;
  localparam int TIMEOUT_DEF = 64;
endpackage

// File: rtl/mem_stage_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (inc && ~&cnt)     cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: runs one req/ready data-memory transaction per memory
// instruction and stalls upstream meanwhile. Optional macro: MEM_TIMEOUT_EN.
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ARQ     = ARQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_enable_in,
  input  logic             wb_enable_in,
  input  logic             store_in,
  input  logic [ARQ-1:0]   addr_in,
  input  logic [ARQ-1:0]   wdata_in,
  input  logic             flush,
  output logic             mem_req,
  output logic             mem_we,
  output logic [ARQ-1:0]   mem_addr,
  output logic [ARQ-1:0]   mem_wdata,
  input  logic             mem_ready,
  input  logic [ARQ-1:0]   mem_rdata,
  output logic             stall,
  output logic [ARQ-1:0]   rdata_out,
  output logic             wb_enable_out,
  output logic [CNT_W-1:0] stall_count
`ifdef MEM_TIMEOUT_EN
  ,
  output logic             mem_err
`endif
);
  state_t state;
  logic   squash;
  logic   wb_q;
  logic   timeout;

  // Gated by rst so a reset mid-transaction releases the pipeline at once.
  assign stall = !rst && ((state == REQ) || (state == IDLE && mem_enable_in && !flush));

  // DONE qualifies write-back live so a flush arriving in DONE still squashes it.
  assign wb_enable_out = (state == DONE) ? (wb_enable_in && !squash && !flush) : wb_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall),
    .clr (1'b0),
    .cnt (stall_count)
  );

`ifdef MEM_TIMEOUT_EN
  logic [7:0] to_cnt;

  sat_counter #(.W(8)) u_to_cnt (
    .clk (clk),
    .rst (rst),
    .inc (1'b1),
    .clr (state != REQ),
    .cnt (to_cnt)
  );

  assign timeout = (state == REQ) && !mem_ready && (to_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mem_err <= 1'b0;
    else if (timeout) mem_err <= 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_out <= '0;
      wb_q      <= 1'b0;
      squash    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_enable_in && !flush) begin
            mem_addr  <= addr_in;
            mem_wdata <= wdata_in;
            mem_we    <= store_in;
            mem_req   <= 1'b1;
            wb_q      <= 1'b0;
            state     <= REQ;
          end else begin
            wb_q <= wb_enable_in && !flush && !mem_enable_in;
          end
        end
        REQ: begin
          wb_q <= 1'b0;
          if (flush) squash <= 1'b1;
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) rdata_out <= mem_rdata;
            state <= DONE;
          end else if (timeout) begin
            // Aborted access: reuse squash to kill the write-back.
            mem_req   <= 1'b0;
            rdata_out <= '0;
            squash    <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          squash <= 1'b0;
          wb_q   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl; inputs driven and outputs sampled on negedge.
module tb_mem_stage_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_enable_in, wb_enable_in, store_in, flush;
  logic [15:0] addr_in, wdata_in;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        stall;
  logic [15:0] rdata_out;
  logic        wb_enable_out;
  logic [15:0] stall_count;
`ifdef MEM_TIMEOUT_EN
  logic        mem_err;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_enable_in(mem_enable_in), .wb_enable_in(wb_enable_in),
    .store_in(store_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall(stall), .rdata_out(rdata_out), .wb_enable_out(wb_enable_out),
    .stall_count(stall_count)
`ifdef MEM_TIMEOUT_EN
    , .mem_err(mem_err)
`endif
  );

  task automatic idle_inputs();
    mem_enable_in = 0; wb_enable_in = 0; store_in = 0; flush = 0;
    addr_in = 0; wdata_in = 0; mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #1;
    tests++; if (stall !== 1'b0 || mem_req !== 1'b0 || wb_enable_out !== 1'b0) begin
      fails++; $display("FAIL reset_ctrl: stall=%b req=%b wb=%b, need 0 0 0", stall, mem_req, wb_enable_out); end
    tests++; if (mem_addr !== 16'd0 || mem_wdata !== 16'd0 || rdata_out !== 16'd0 || stall_count !== 16'd0 || mem_we !== 1'b0) begin
      fails++; $display("FAIL reset_data: addr=%0d wdata=%0d rdata=%0d cnt=%0d we=%b, need all 0", mem_addr, mem_wdata, rdata_out, stall_count, mem_we); end
    @(negedge clk); @(negedge clk);
    rst = 0;
  endtask

  task automatic test_load();
    @(negedge clk);
    mem_enable_in = 1; wb_enable_in = 1; store_in = 0; addr_in = 16'd1421;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL load_detect_stall: got %b need 1", stall); end
    @(negedge clk);
    tests++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'd1421 || stall !== 1'b1) begin
      fails++; $display("FAIL load_req1: req=%b we=%b addr=%0d stall=%b need 1 0 1421 1", mem_req, mem_we, mem_addr, stall); end
    @(negedge clk);
    mem_ready = 1; mem_rdata = 16'd1821;
    #1;
    tests++; if (mem_req !== 1'b1 || stall !== 1'b1) begin
      fails++; $display("FAIL load_req2: req=%b stall=%b need 1 1", mem_req, stall); end
    @(negedge clk);
    mem_ready = 0; mem_rdata = 16'hDEAD;
    #1;
    tests++; if (mem_req !== 1'b0 || stall !== 1'b0 || rdata_out !== 16'd1821 || wb_enable_out !== 1'b1) begin
      fails++; $display("FAIL load_done: req=%b stall=%b rdata=%0d wb=%b need 0 0 1821 1", mem_req, stall, rdata_out, wb_enable_out); end
    tests++; if (stall_count !== 16'd3) begin fails++; $display("FAIL load_stall_count: got %0d need 3", stall_count); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_store();
    @(negedge clk);
    mem_enable_in = 1; wb_enable_in = 0; store_in = 1; addr_in = 16'd1421; wdata_in = 16'd1114;
    @(negedge clk);
    mem_ready = 1; mem_rdata = 16'd7;
    #1;
    tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'd1114 || mem_addr !== 16'd1421 || stall !== 1'b1) begin
      fails++; $display("FAIL store_req: req=%b we=%b wdata=%0d addr=%0d stall=%b need 1 1 1114 1421 1", mem_req, mem_we, mem_wdata, mem_addr, stall); end
    @(negedge clk);
    mem_ready = 0;
    #1;
    tests++; if (stall !== 1'b0 || wb_enable_out !== 1'b0 || rdata_out !== 16'd1821 || stall_count !== 16'd5) begin
      fails++; $display("FAIL store_done: stall=%b wb=%b rdata=%0d cnt=%0d need 0 0 1821 5", stall, wb_enable_out, rdata_out, stall_count); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_nonmem();
    @(negedge clk);
    wb_enable_in = 1;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL nonmem_stall: got %b need 0", stall); end
    @(negedge clk);
    wb_enable_in = 1; flush = 1;
    #1;
    tests++; if (wb_enable_out !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0) begin
      fails++; $display("FAIL nonmem_wb: wb=%b stall=%b req=%b need 1 0 0", wb_enable_out, stall, mem_req); end
    @(negedge clk);
    flush = 0; wb_enable_in = 0;
    #1;
    tests++; if (wb_enable_out !== 1'b0) begin fails++; $display("FAIL nonmem_flushed: wb=%b need 0", wb_enable_out); end
    // Flushed memory instruction: no transaction at all.
    mem_enable_in = 1; wb_enable_in = 1; flush = 1;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL flushed_mem_stall: got %b need 0", stall); end
    @(negedge clk);
    tests++; if (mem_req !== 1'b0 || wb_enable_out !== 1'b0) begin
      fails++; $display("FAIL flushed_mem: req=%b wb=%b need 0 0", mem_req, wb_enable_out); end
    idle_inputs();
  endtask

  task automatic test_flush_req();
    @(negedge clk);
    mem_enable_in = 1; wb_enable_in = 1; store_in = 0; addr_in = 16'd100;
    @(negedge clk);
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0; mem_ready = 1; mem_rdata = 16'hBEEF;
    #1;
    tests++; if (mem_req !== 1'b1 || stall !== 1'b1) begin
      fails++; $display("FAIL flush_req_held: req=%b stall=%b need 1 1", mem_req, stall); end
    @(negedge clk);
    mem_ready = 0;
    #1;
    tests++; if (rdata_out !== 16'hBEEF || wb_enable_out !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL flush_done: rdata=%h wb=%b stall=%b need beef 0 0", rdata_out, wb_enable_out, stall); end
    @(negedge clk);
    mem_enable_in = 0; wb_enable_in = 1;
    @(negedge clk);
    tests++; if (wb_enable_out !== 1'b1) begin fails++; $display("FAIL flush_next_instr: wb=%b need 1", wb_enable_out); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    mem_enable_in = 1; wb_enable_in = 1; addr_in = 16'd10;
    @(negedge clk);
    mem_ready = 1; mem_rdata = 16'h1111;
    @(negedge clk);
    mem_ready = 0;
    #1;
    tests++; if (stall !== 1'b0 || mem_req !== 1'b0 || rdata_out !== 16'h1111) begin
      fails++; $display("FAIL b2b_done1: stall=%b req=%b rdata=%h need 0 0 1111", stall, mem_req, rdata_out); end
    @(negedge clk);
    addr_in = 16'd20;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL b2b_detect2: stall=%b need 1", stall); end
    @(negedge clk);
    mem_ready = 1; mem_rdata = 16'h2222;
    #1;
    tests++; if (mem_addr !== 16'd20 || mem_req !== 1'b1) begin
      fails++; $display("FAIL b2b_req2: addr=%0d req=%b need 20 1", mem_addr, mem_req); end
    @(negedge clk);
    mem_ready = 0;
    #1;
    tests++; if (rdata_out !== 16'h2222 || wb_enable_out !== 1'b1) begin
      fails++; $display("FAIL b2b_done2: rdata=%h wb=%b need 2222 1", rdata_out, wb_enable_out); end
    @(negedge clk);
    idle_inputs();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    @(negedge clk);
    mem_enable_in = 1; wb_enable_in = 1; addr_in = 16'd55;
    @(negedge clk);
    while (mem_req === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    tests++; if (n !== 64) begin fails++; $display("FAIL timeout_cycles: got %0d need 64", n); end
    tests++; if (mem_err !== 1'b1 || rdata_out !== 16'd0 || wb_enable_out !== 1'b0) begin
      fails++; $display("FAIL timeout_done: err=%b rdata=%0d wb=%b need 1 0 0", mem_err, rdata_out, wb_enable_out); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    tests++; if (mem_err !== 1'b1) begin fails++; $display("FAIL timeout_sticky: err=%b need 1", mem_err); end
  endtask
`endif

  task automatic test_reset_mid_req();
    @(negedge clk);
    mem_enable_in = 1; wb_enable_in = 1; addr_in = 16'd77;
    @(negedge clk);
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rst_mid_pre: req=%b need 1", mem_req); end
    #2 rst = 1;
    #1;
    tests++; if (mem_req !== 1'b0 || stall !== 1'b0 || wb_enable_out !== 1'b0 || mem_addr !== 16'd0 || rdata_out !== 16'd0 || stall_count !== 16'd0) begin
      fails++; $display("FAIL rst_mid_async: req=%b stall=%b wb=%b addr=%0d rdata=%0d cnt=%0d need all 0", mem_req, stall, wb_enable_out, mem_addr, rdata_out, stall_count); end
    @(negedge clk);
    idle_inputs();
    rst = 0;
    @(negedge clk);
    wb_enable_in = 1;
    #1;
    tests++; if (mem_req !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL rst_mid_after: req=%b stall=%b need 0 0", mem_req, stall); end
    @(negedge clk);
    tests++; if (wb_enable_out !== 1'b1) begin fails++; $display("FAIL rst_mid_idle: wb=%b need 1", wb_enable_out); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_nonmem();
    test_flush_req();
    test_back_to_back();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
